// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: word RAM with byte lanes and programmable wait states.
// Define DMEM_ERR_EN to add err_o (out-of-range index / illegal write lane mask); otherwise indices wrap modulo DEPTH.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o
`ifdef DMEM_ERR_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_data;
  logic [29:0] r_word;
  logic [31:0] r_mem [DEPTH];
`ifdef DMEM_ERR_EN
  logic        r_err;
`endif

  logic              w_useIn;
  logic              w_we;
  logic [3:0]        w_sel;
  logic [31:0]       w_data;
  logic [29:0]       w_wordIdx;
  logic [ADDR_W-1:0] w_idx;
  logic              w_commit;
  logic              w_err;
  logic              w_unused;

  // With zero wait states the commit happens on the capture edge, so the live inputs are used.
  assign w_useIn   = (r_state == IDLE);
  assign w_we      = w_useIn ? we_i          : r_we;
  assign w_sel     = w_useIn ? sel_i         : r_sel;
  assign w_data    = w_useIn ? data_i        : r_data;
  assign w_wordIdx = w_useIn ? addr_i[31:2]  : r_word;
  assign w_idx     = ADDR_W'(w_wordIdx % 30'(DEPTH));
  assign w_unused  = ^addr_i[1:0];

  assign w_commit = ce_i & (((r_state == IDLE) && (WS == 4'd0)) ||
                            ((r_state == WAIT) && (r_cnt == 4'd1)));

`ifdef DMEM_ERR_EN
  assign w_err = (w_wordIdx >= 30'(DEPTH)) ||
                 (w_we && !(w_sel inside {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0111,
                                          4'b0011, 4'b0001, 4'b0100, 4'b0010}));
  assign err_o = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign stall_o = ce_i & (r_state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_data  <= 32'd0;
      r_word  <= 30'd0;
      data_o  <= 32'd0;
`ifdef DMEM_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
`ifdef DMEM_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (ce_i) begin
            r_we   <= we_i;
            r_sel  <= sel_i;
            r_data <= data_i;
            r_word <= addr_i[31:2];
            if (WS == 4'd0) begin
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WS;
            end
          end
        end
        WAIT: begin
          if (!ce_i) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state <= DONE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_commit) begin
        if (!w_we) data_o <= w_err ? 32'd0 : r_mem[w_idx];
`ifdef DMEM_ERR_EN
        r_err <= w_err;
`endif
      end
    end
  end

  // RAM is deliberately not reset; only lanes enabled by the captured mask are written.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_we && !w_err) begin
      for (int l = 0; l < 4; l++) begin
        if (w_sel[l]) r_mem[w_idx][8*l +: 8] <= w_data[8*l +: 8];
      end
    end
  end

endmodule
